conv1d_sram_arbiter: RTL and testbench
======================================

Name: conv1d_sram_arbiter

Overview:
- Round-robin arbiter that shares one single-ported, fixed-latency conv1d SRAM between NUM_REQ OBI requesters, e.g. the host bus port and the accelerator load/store unit.
- Selects one requester per cycle and forwards its request to the SRAM.
- Returns OBI gnt to the winner only.
- Tracks the owner of every in-flight access so that rvalid and rdata reach the correct requester exactly DELAY cycles after the grant.

Parameters:
- NUM_REQ, 2: number of OBI requesters; must be >= 2.
- AW, 32: address width.
- DW, 32: data width; byte-enable width is DW/8.
- DELAY, 1: SRAM read latency in cycles; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  NUM_REQ  per-requester OBI req
- we_i  in  NUM_REQ  per-requester write enable
- be_i  in  NUM_REQ x DW/8  per-requester byte enable
- addr_i  in  NUM_REQ x AW  per-requester address
- wdata_i  in  NUM_REQ x DW  per-requester write data
- gnt_o  out  NUM_REQ  per-requester OBI gnt
- rvalid_o  out  NUM_REQ  per-requester OBI rvalid
- rdata_o  out  NUM_REQ x DW  per-requester read data
- sram_req_o  out  1  SRAM request
- sram_we_o  out  1  SRAM write enable
- sram_be_o  out  DW/8  SRAM byte enable
- sram_addr_o  out  AW  SRAM address
- sram_wdata_o  out  DW  SRAM write data
- sram_gnt_i  in  1  SRAM grant
- sram_rdata_i  in  DW  SRAM read data, valid DELAY cycles after an accepted request
- busy_o  out  1  at least one access in flight

Behaviour:
- State:
  - rr_ptr, width clog2(NUM_REQ): highest-priority index.
  - Response pipeline of DELAY stages, each stage holding {valid, id}.
- Reset (rst_i high, asynchronous):
  - rr_ptr=0; all pipeline stages cleared (valid=0, id=0).
  - Outputs during reset: gnt_o=0, rvalid_o=0, rdata_o=0, busy_o=0.
  - sram_req_o=0 while rst_i is high, regardless of req_i.
- Selection (combinational):
  - winner = first index i with req_i[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - any_req = OR of req_i.
- SRAM request (combinational, no added latency):
  - sram_req_o = any_req.
  - sram_we_o, sram_be_o, sram_addr_o and sram_wdata_o are the winner's fields.
  - When any_req=0 these fields are driven to 0.
- Grant: gnt_o[winner] = sram_gnt_i when any_req=1; all other gnt_o bits are 0.
- Accept event: acc = sram_req_o & sram_gnt_i.
  - On acc, rr_ptr <= (winner+1) mod NUM_REQ. NUM_REQ need not be a power of two; wrap explicitly.
  - With no acc, including a stalled SRAM (sram_gnt_i=0), rr_ptr holds.
- Pipeline:
  - Stage 0 loads {acc, winner}; stage k loads stage k-1.
  - Pipeline advances every cycle, independent of new requests.
- Response: with last stage = {v, id}:
  - rvalid_o[id] = v.
  - rdata_o[id] = sram_rdata_i when v=1.
  - All other rdata_o lanes and non-owner rvalid bits are 0.
  - Write accesses also produce rvalid (rdata content don't-care, still routed).
- busy_o = OR of all stage valids.
- OBI requester rule: req, we, be, addr and wdata hold stable until gnt. The arbiter must not drop a pending requester. A requester deasserting req before gnt is a protocol violation and produces no response.
- Back-to-back: one accept per cycle max. Grants alternate between simultaneous requesters (fairness bound: every requester is granted within NUM_REQ accepts).
- Simultaneous response and new grant to the same requester in one cycle is legal; both gnt_o and rvalid_o are asserted.
- Reset mid-operation: in-flight responses are discarded; no rvalid after reset deassertion for pre-reset accepts.

Test Plan:
1. Reset, then req_i=2'b00 for 5 cycles -> sram_req_o=0, gnt_o=0, rvalid_o=0, busy_o=0.
2. NUM_REQ=2, DELAY=1, sram_gnt_i=1. req0 reads addr 0x10 alone, SRAM returns 0xCAFE0010 -> gnt_o=01 same cycle; next cycle rvalid_o=01, rdata_o[0]=0xCAFE0010, rdata_o[1]=0.
3. Both requesters hold req for 4 accepts, rr_ptr=0 after reset -> grant order 0,1,0,1. rvalid follows one cycle later in the same order, each with its own address's data.
4. sram_gnt_i=0 for 3 cycles with both requesting -> gnt_o=00, rr_ptr unchanged, no rvalid. On sram_gnt_i=1, requester 0 is granted first.
5. DELAY=3, req1 write (be=4'b0011, wdata 0x1234) then req0 read -> rvalid_o[1] 3 cycles after the first gnt, rvalid_o[0] on the next cycle; busy_o high throughout.
6. Assert rst_i with 2 accesses in flight (DELAY=3) -> outputs 0 immediately. After release, no rvalid occurs for those accesses and the first grant goes to requester 0.

Source files
------------

// File: rtl/conv1d_sram_arbiter.sv
// conv1d_sram_arbiter
// Round-robin arbiter sharing one single-ported, fixed-latency SRAM between
// NUM_REQ OBI requesters. Requests pass through to the SRAM combinationally.
// A DELAY-deep {valid, id} pipeline routes each response back to the
// requester that was granted DELAY cycles earlier.
module conv1d_sram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DELAY   = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             we_i,
  input  logic [NUM_REQ-1:0][DW/8-1:0]   be_i,
  input  logic [NUM_REQ-1:0][AW-1:0]     addr_i,
  input  logic [NUM_REQ-1:0][DW-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             rvalid_o,
  output logic [NUM_REQ-1:0][DW-1:0]     rdata_o,
  output logic                           sram_req_o,
  output logic                           sram_we_o,
  output logic [DW/8-1:0]                sram_be_o,
  output logic [AW-1:0]                  sram_addr_o,
  output logic [DW-1:0]                  sram_wdata_o,
  input  logic                           sram_gnt_i,
  input  logic [DW-1:0]                  sram_rdata_i,
  output logic                           busy_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             winner;
  logic                      any_req;
  logic                      acc;
  logic [DELAY-1:0]          pipe_v;
  logic [DELAY-1:0][PW-1:0]  pipe_id;

  // Pick the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        winner = PW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req_i;

  // Forward the winner's fields; idle bus is all zeros and reset blocks requests.
  always_comb begin
    sram_req_o   = any_req & ~rst_i;
    sram_we_o    = 1'b0;
    sram_be_o    = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (any_req) begin
      sram_we_o    = we_i[winner];
      sram_be_o    = be_i[winner];
      sram_addr_o  = addr_i[winner];
      sram_wdata_o = wdata_i[winner];
    end
  end

  // Only the winner sees the SRAM grant.
  always_comb begin
    gnt_o = '0;
    if (any_req && !rst_i) gnt_o[winner] = sram_gnt_i;
  end

  assign acc = sram_req_o & sram_gnt_i;

  // Priority moves just past the accepted requester; a stalled SRAM holds it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (acc) begin
      if (winner == PW'(NUM_REQ - 1)) rr_ptr <= '0;
      else                            rr_ptr <= winner + PW'(1);
    end
  end

  // Owner pipeline shifts every cycle so responses line up with SRAM latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= acc;
      pipe_id[0] <= winner;
      for (int k = 1; k < DELAY; k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_id[k] <= pipe_id[k-1];
      end
    end
  end

  // Route the returning response to its owner only; other lanes stay zero.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (pipe_v[DELAY-1]) begin
      rvalid_o[pipe_id[DELAY-1]] = 1'b1;
      rdata_o[pipe_id[DELAY-1]]  = sram_rdata_i;
    end
  end

  assign busy_o = |pipe_v;

endmodule

// File: tb/tb_conv1d_sram_arbiter.sv
// Directed bench for conv1d_sram_arbiter: one instance with DELAY=1 and one
// with DELAY=3 share the requester inputs; each has its own SRAM model that
// returns {16'hCAFE, addr[15:0]} after the instance's latency.
module tb_conv1d_sram_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NR-1:0]             req = '0;
  logic [NR-1:0]             we = '0;
  logic [NR-1:0][DW/8-1:0]   be = '0;
  logic [NR-1:0][AW-1:0]     addr = '0;
  logic [NR-1:0][DW-1:0]     wdata = '0;
  logic                      sram_gnt = 1'b0;

  logic [NR-1:0]             gnt1, rvalid1, gnt3, rvalid3;
  logic [NR-1:0][DW-1:0]     rdata1, rdata3;
  logic                      sram_req1, sram_we1, sram_req3, sram_we3;
  logic [DW/8-1:0]           sram_be1, sram_be3;
  logic [AW-1:0]             sram_addr1, sram_addr3;
  logic [DW-1:0]             sram_wdata1, sram_wdata3;
  logic [DW-1:0]             sram_rdata1, sram_rdata3;
  logic                      busy1, busy3;
  logic [2:0][DW-1:0]        d3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  conv1d_sram_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .DELAY(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .sram_req_o(sram_req1), .sram_we_o(sram_we1),
    .sram_be_o(sram_be1), .sram_addr_o(sram_addr1), .sram_wdata_o(sram_wdata1),
    .sram_gnt_i(sram_gnt), .sram_rdata_i(sram_rdata1), .busy_o(busy1)
  );

  conv1d_sram_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .DELAY(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rvalid3),
    .rdata_o(rdata3), .sram_req_o(sram_req3), .sram_we_o(sram_we3),
    .sram_be_o(sram_be3), .sram_addr_o(sram_addr3), .sram_wdata_o(sram_wdata3),
    .sram_gnt_i(sram_gnt), .sram_rdata_i(sram_rdata3), .busy_o(busy3)
  );

  // SRAM models: data is a fixed function of the address presented.
  always_ff @(posedge clk) begin
    sram_rdata1 <= {16'hCAFE, sram_addr1[15:0]};
    d3[0]       <= {16'hCAFE, sram_addr3[15:0]};
    d3[1]       <= d3[0];
    d3[2]       <= d3[1];
  end
  assign sram_rdata3 = d3[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; we = '0; be = '0; addr = '0; wdata = '0; sram_gnt = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset and idle
    #2;
    check("rst_gnt", 64'(gnt1), 64'h0);
    check("rst_busy", 64'(busy1), 64'h0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      check("idle_req", 64'(sram_req1), 64'h0);
      check("idle_gnt", 64'(gnt1), 64'h0);
      check("idle_rvalid", 64'(rvalid1), 64'h0);
      check("idle_busy", 64'(busy1), 64'h0);
    end

    // 2: single read from requester 0, DELAY=1
    cyc();
    sram_gnt = 1'b1;
    req = 2'b01; addr[0] = 32'h10;
    #1;
    check("t2_gnt", 64'(gnt1), 64'h1);
    check("t2_addr", 64'(sram_addr1), 64'h10);
    check("t2_sreq", 64'(sram_req1), 64'h1);
    cyc();
    req = 2'b00;
    #1;
    check("t2_rvalid", 64'(rvalid1), 64'h1);
    check("t2_rdata0", 64'(rdata1[0]), 64'hCAFE0010);
    check("t2_rdata1", 64'(rdata1[1]), 64'h0);
    check("t2_busy", 64'(busy1), 64'h1);

    // 3: both requesting, alternating grants
    do_reset();
    sram_gnt = 1'b1;
    addr[0] = 32'h20; addr[1] = 32'h30;
    for (int k = 0; k < 5; k++) begin
      cyc();
      req = (k < 4) ? 2'b11 : 2'b00;
      #1;
      if (k < 4) check("t3_gnt", 64'(gnt1), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k == 0) begin
        check("t3_rv_first", 64'(rvalid1), 64'h0);
      end else if (k % 2 == 1) begin
        check("t3_rv0", 64'(rvalid1), 64'h1);
        check("t3_rd0", 64'(rdata1[0]), 64'hCAFE0020);
      end else begin
        check("t3_rv1", 64'(rvalid1), 64'h2);
        check("t3_rd1", 64'(rdata1[1]), 64'hCAFE0030);
      end
    end

    // 4: stalled SRAM keeps the pointer
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc();
      req = 2'b11; sram_gnt = 1'b0;
      #1;
      check("t4_stall_gnt", 64'(gnt1), 64'h0);
      check("t4_stall_rv", 64'(rvalid1), 64'h0);
    end
    cyc();
    sram_gnt = 1'b1;
    #1;
    check("t4_first_gnt", 64'(gnt1), 64'h1);
    check("t4_rv_after_stall", 64'(rvalid1), 64'h0);
    cyc();
    #1;
    check("t4_second_gnt", 64'(gnt1), 64'h2);
    check("t4_rv", 64'(rvalid1), 64'h1);

    // 5: DELAY=3, write from requester 1 then read from requester 0
    do_reset();
    sram_gnt = 1'b1;
    cyc();
    req = 2'b10; we = 2'b10; be[1] = 4'b0011; wdata[1] = 32'h1234; addr[1] = 32'h40;
    #1;
    check("t5_gnt_w", 64'(gnt3), 64'h2);
    check("t5_we", 64'(sram_we3), 64'h1);
    check("t5_be", 64'(sram_be3), 64'h3);
    check("t5_wdata", 64'(sram_wdata3), 64'h1234);
    cyc();
    req = 2'b01; we = 2'b00; addr[0] = 32'h50;
    #1;
    check("t5_gnt_r", 64'(gnt3), 64'h1);
    check("t5_we_r", 64'(sram_we3), 64'h0);
    check("t5_busy_c1", 64'(busy3), 64'h1);
    check("t5_rv_c1", 64'(rvalid3), 64'h0);
    cyc();
    req = 2'b00;
    #1;
    check("t5_busy_c2", 64'(busy3), 64'h1);
    check("t5_rv_c2", 64'(rvalid3), 64'h0);
    cyc();
    #1;
    check("t5_rv_w", 64'(rvalid3), 64'h2);
    check("t5_rd_w", 64'(rdata3[1]), 64'hCAFE0040);
    check("t5_busy_c3", 64'(busy3), 64'h1);
    cyc();
    #1;
    check("t5_rv_r", 64'(rvalid3), 64'h1);
    check("t5_rd_r", 64'(rdata3[0]), 64'hCAFE0050);
    check("t5_rd_r_other", 64'(rdata3[1]), 64'h0);
    check("t5_busy_c4", 64'(busy3), 64'h1);
    cyc();
    #1;
    check("t5_busy_end", 64'(busy3), 64'h0);
    check("t5_rv_end", 64'(rvalid3), 64'h0);

    // 6: reset with two accesses in flight
    do_reset();
    sram_gnt = 1'b1;
    cyc();
    req = 2'b01; addr[0] = 32'h60;
    #1;
    check("t6_gnt0", 64'(gnt3), 64'h1);
    cyc();
    req = 2'b10; addr[1] = 32'h70;
    #1;
    check("t6_gnt1", 64'(gnt3), 64'h2);
    cyc();
    req = 2'b11;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 64'(busy3), 64'h0);
    check("t6_rst_gnt", 64'(gnt3), 64'h0);
    check("t6_rst_sreq", 64'(sram_req3), 64'h0);
    check("t6_rst_rv", 64'(rvalid3), 64'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("t6_post_gnt", 64'(gnt3), 64'h1);
    check("t6_post_rv0", 64'(rvalid3), 64'h0);
    cyc();
    req = 2'b00;
    #1;
    check("t6_post_rv1", 64'(rvalid3), 64'h0);
    cyc();
    #1;
    check("t6_post_rv2", 64'(rvalid3), 64'h0);
    cyc();
    #1;
    check("t6_new_rv", 64'(rvalid3), 64'h1);
    check("t6_new_rd", 64'(rdata3[0]), 64'hCAFE0060);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
